// File: rtl/svcs_frame_pkg.sv
// Shared SVCS frame definitions: transfer type codes, header field layout,
// and the word-count / header-pack / string-tail-mask helpers.
package svcs_frame_pkg;

    typedef enum logic [2:0] {
        SVCS_BYTE   = 3'd0,
        SVCS_INT    = 3'd1,
        SVCS_REAL   = 3'd2,
        SVCS_INTV   = 3'd3,
        SVCS_REALV  = 3'd4,
        SVCS_STRING = 3'd5
    } svcs_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_TRAIL
    } pack_state_e;

    localparam int HDR_TYPE_LSB = 29;
    localparam int HDR_TYPE_W   = 3;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_SEQ_W    = 13;
    localparam int HDR_SIZE_LSB = 0;
    localparam int HDR_SIZE_W   = 16;

    function automatic logic [16:0] svcs_word_count(input logic [2:0] t, input logic [15:0] size);
        logic [16:0] wc;
        case (t)
            SVCS_BYTE, SVCS_INT: wc = 17'd1;
            SVCS_REAL:           wc = 17'd2;
            SVCS_INTV:           wc = {1'b0, size};
            SVCS_REALV:          wc = {size, 1'b0};
            SVCS_STRING:         wc = ({1'b0, size} + 17'd3) >> 2;
            default:             wc = '0;
        endcase
        return wc;
    endfunction

    // Scalar types carry no size; the field is zeroed so the receiver never sees junk.
    function automatic logic [31:0] svcs_hdr_pack(input logic [HDR_TYPE_W-1:0] t,
                                                  input logic [HDR_SEQ_W-1:0]  s,
                                                  input logic [HDR_SIZE_W-1:0] size);
        logic [31:0] w;
        w = '0;
        w[HDR_TYPE_LSB +: HDR_TYPE_W] = t;
        w[HDR_SEQ_LSB  +: HDR_SEQ_W]  = s;
        if (t != SVCS_BYTE && t != SVCS_INT && t != SVCS_REAL)
            w[HDR_SIZE_LSB +: HDR_SIZE_W] = size;
        return w;
    endfunction

    function automatic logic [31:0] svcs_str_mask(input logic [15:0] size);
        logic [31:0] m;
        case (size & 16'h0003)
            16'd1:   m = 32'h0000_00FF;
            16'd2:   m = 32'h0000_FFFF;
            16'd3:   m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/svcs_frame_oreg.sv
// One-entry valid/ready output register; loads in the cycle slot_free is high, data visible next cycle.
// Holds data/valid stable while stalled; slot_free = empty or being drained this cycle.
module svcs_frame_oreg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         slot_free,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    assign slot_free = !vld_q || out_rdy;
    assign out_vld   = vld_q;
    assign out_dat   = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (slot_free) begin
            vld_d = in_vld;
            if (in_vld)
                dat_d = in_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/svcs_frame_packer.sv
// Frames SVCS transfers as header, W payload words, XOR trailer; header visible one cycle after accept.
// Stalls hdr/data intake whenever the single output slot is occupied and not draining.
module svcs_frame_packer
    import svcs_frame_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [2:0]  hdr_type,
    input  logic [15:0] hdr_size,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        err,
    output logic [12:0] seq
);

    localparam logic [16:0] MAX_SIZE_L = MAX_SIZE[16:0];

    pack_state_e state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [31:0] csum_q, csum_d;
    logic [12:0] seq_q, seq_d;
    logic [2:0]  type_q, type_d;
    logic [15:0] size_q, size_d;
    logic        err_q, err_d;

    logic        slot_free;
    logic        oreg_in_vld;
    logic [32:0] oreg_in_dat;
    logic [32:0] oreg_out_dat;
    logic        hdr_fire, data_fire, hdr_illegal, hdr_sized;
    logic [16:0] hdr_wc;
    logic [31:0] hdr_word, pay_mask, pay_word;

    // Gated by rst so both readies read 0 while reset is held.
    assign hdr_ready  = !rst && state_q == ST_IDLE    && slot_free;
    assign data_ready = !rst && state_q == ST_PAYLOAD && slot_free;
    assign hdr_fire   = hdr_valid  && hdr_ready;
    assign data_fire  = data_valid && data_ready;

    assign hdr_sized   = hdr_type == SVCS_INTV || hdr_type == SVCS_REALV || hdr_type == SVCS_STRING;
    assign hdr_illegal = hdr_type > 3'd5 || (hdr_sized && {1'b0, hdr_size} > MAX_SIZE_L);
    assign hdr_wc      = svcs_word_count(hdr_type, hdr_size);
    assign hdr_word    = svcs_hdr_pack(hdr_type, seq_q, hdr_size);

    always_comb begin
        pay_mask = 32'hFFFF_FFFF;
        if (type_q == SVCS_BYTE)
            pay_mask = 32'h0000_00FF;
        else if (type_q == SVCS_STRING && cnt_q == 17'd1)
            pay_mask = svcs_str_mask(size_q);
        pay_word = data & pay_mask;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        type_d      = type_q;
        size_d      = size_q;
        err_d       = 1'b0;
        oreg_in_vld = 1'b0;
        oreg_in_dat = '0;
        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (hdr_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        oreg_in_vld = 1'b1;
                        oreg_in_dat = {1'b0, hdr_word};
                        csum_d      = hdr_word;
                        seq_d       = seq_q + 13'd1;
                        type_d      = hdr_type;
                        size_d      = hdr_size;
                        cnt_d       = hdr_wc;
                        state_d     = (hdr_wc == 17'd0) ? ST_TRAIL : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (data_fire) begin
                    oreg_in_vld = 1'b1;
                    oreg_in_dat = {1'b0, pay_word};
                    csum_d      = csum_q ^ pay_word;
                    cnt_d       = cnt_q - 17'd1;
                    if (cnt_q == 17'd1)
                        state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (slot_free) begin
                    oreg_in_vld = 1'b1;
                    oreg_in_dat = {1'b1, csum_q};
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            seq_q   <= '0;
            type_q  <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            seq_q   <= seq_d;
            type_q  <= type_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    svcs_frame_oreg #(.W(33)) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (oreg_in_vld),
        .in_dat    (oreg_in_dat),
        .slot_free (slot_free),
        .out_vld   (out_valid),
        .out_rdy   (out_ready),
        .out_dat   (oreg_out_dat)
    );

    assign out_data = oreg_out_dat[31:0];
    assign out_last = oreg_out_dat[32];
    assign err      = err_q;
    assign seq      = seq_q;

endmodule

// File: tb/tb_svcs_frame_packer.sv
// Directed bench for svcs_frame_packer: inputs driven 1 time unit after the rising edge,
// outputs sampled on the falling edge.
module tb_svcs_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_valid, hdr_ready;
    logic [2:0]  hdr_type;
    logic [15:0] hdr_size;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_last, err;
    logic [12:0] seq;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_viol;
    logic [32:0] beats[$];
    int          beat_cyc[$];

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    svcs_frame_packer #(.MAX_SIZE(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_type   (hdr_type),
        .hdr_size   (hdr_size),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .err        (err),
        .seq        (seq)
    );

    task automatic do_reset();
        rst        = 1'b1;
        hdr_valid  = 1'b0;
        hdr_type   = '0;
        hdr_size   = '0;
        data_valid = 1'b0;
        data       = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_hdr(input logic [2:0] t, input logic [15:0] s);
        int n = 0;
        hdr_valid = 1'b1;
        hdr_type  = t;
        hdr_size  = s;
        do begin
            @(negedge clk);
            n++;
        end while (!hdr_ready && n < 200);
        checks++;
        if (!hdr_ready) begin
            errors++;
            $display("FAIL hdr_accept_timeout: hdr_ready=%0b after %0d cycles, want 1", hdr_ready, n);
        end
        @(posedge clk);
        #1 hdr_valid = 1'b0;
    endtask

    task automatic send_data(input logic [31:0] w);
        int n = 0;
        data_valid = 1'b1;
        data       = w;
        do begin
            @(negedge clk);
            n++;
        end while (!data_ready && n < 200);
        checks++;
        if (!data_ready) begin
            errors++;
            $display("FAIL data_accept_timeout: data_ready=%0b after %0d cycles, want 1", data_ready, n);
        end
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    // Gathers up to n transferred beats; records any change of a stalled word in stall_viol.
    task automatic collect(input int n, input bit rnd, input int budget);
        logic [32:0] hold = '0;
        bit          have_hold = 1'b0;
        int          g = 0;
        beats.delete();
        beat_cyc.delete();
        stall_viol = 0;
        while (beats.size() < n && g < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (have_hold && (!out_valid || {out_last, out_data} !== hold))
                stall_viol++;
            have_hold = out_valid && !out_ready;
            hold      = {out_last, out_data};
            if (out_valid && out_ready) begin
                beats.push_back({out_last, out_data});
                beat_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1 g++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hdr_valid = 1'b0; hdr_type = '0; hdr_size = '0;
        data_valid = 1'b0; data = '0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_last, hdr_ready, data_ready, err, seq} !== 50'd0) begin
            errors++;
            $display("FAIL reset_outputs: v=%0b d=%h l=%0b hr=%0b dr=%0b e=%0b s=%0d, want all 0",
                     out_valid, out_data, out_last, hdr_ready, data_ready, err, seq);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1 || data_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: hr=%0b dr=%0b v=%0b, want 1 0 0", hdr_ready, data_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_int();
        logic [32:0] exp [3] = '{{1'b0, 32'h2000_0000}, {1'b0, 32'h1234_5678}, {1'b1, 32'h3234_5678}};
        do_reset();
        data_valid = 1'b1;
        data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_data_ready: got %0b want 0", data_ready);
        end
        @(posedge clk);
        #1 data_valid = 1'b0;
        fork
            begin send_hdr(3'd1, 16'd0); send_data(32'h1234_5678); end
            collect(3, 1'b0, 40);
        join
        checks++;
        if (beats.size() != 3) begin
            errors++;
            $display("FAIL int_beats: got %0d beats want 3", beats.size());
        end
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin
                errors++;
                $display("FAIL int_word%0d: got %h want %h", i, beats[i], exp[i]);
            end
        end
        checks++;
        if (seq !== 13'd1) begin
            errors++;
            $display("FAIL int_seq: got %0d want 1", seq);
        end
    endtask

    task automatic test_string();
        logic [32:0] exp [4] = '{{1'b0, 32'hA000_0005}, {1'b0, 32'h6463_6261},
                                 {1'b0, 32'h0000_0065}, {1'b1, 32'hC463_6201}};
        do_reset();
        fork
            begin send_hdr(3'd5, 16'd5); send_data(32'h6463_6261); send_data(32'hFFFF_FF65); end
            collect(4, 1'b0, 40);
        join
        checks++;
        if (beats.size() != 4) begin
            errors++;
            $display("FAIL str_beats: got %0d beats want 4", beats.size());
        end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin
                errors++;
                $display("FAIL str_word%0d: got %h want %h", i, beats[i], exp[i]);
            end
        end
    endtask

    task automatic test_empty_realv();
        do_reset();
        fork
            send_hdr(3'd4, 16'd0);
            collect(3, 1'b0, 20);
        join
        checks++;
        if (beats.size() != 2) begin
            errors++;
            $display("FAIL realv0_beats: got %0d beats want 2", beats.size());
        end
        if (beats.size() >= 2) begin
            checks++;
            if (beats[0] !== {1'b0, 32'h8000_0000} || beats[1] !== {1'b1, 32'h8000_0000}) begin
                errors++;
                $display("FAIL realv0_words: got %h %h want 0_80000000 1_80000000", beats[0], beats[1]);
            end
        end
    endtask

    task automatic test_reject();
        int seen = 0;
        do_reset();
        send_hdr(3'd7, 16'd0);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rej_type_err: err=%0b v=%0b want 1 0", err, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rej_type_pulse: err=%0b want 0", err);
        end
        send_hdr(3'd3, 16'd1025);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rej_size_err: err=%0b want 1", err);
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || seq !== 13'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rej_quiet: valid_cycles=%0d seq=%0d err=%0b want 0 0 0", seen, seq, err);
        end
        @(posedge clk);
        #1;
        send_hdr(3'd3, 16'd1024);
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h6000_0400 || seq !== 13'd1) begin
            errors++;
            $display("FAIL max_size_accept: err=%0b v=%0b d=%h seq=%0d want 0 1 60000400 1",
                     err, out_valid, out_data, seq);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp [6] = '{{1'b0, 32'h6000_0004}, {1'b0, 32'h1111_1111}, {1'b0, 32'h2222_2222},
                                 {1'b0, 32'h3333_3333}, {1'b0, 32'h4444_4444}, {1'b1, 32'h2444_4440}};
        do_reset();
        fork
            begin
                send_hdr(3'd3, 16'd4);
                send_data(32'h1111_1111);
                send_data(32'h2222_2222);
                send_data(32'h3333_3333);
                send_data(32'h4444_4444);
            end
            collect(6, 1'b1, 300);
        join
        checks++;
        if (beats.size() != 6 || stall_viol != 0) begin
            errors++;
            $display("FAIL bp_count: beats=%0d stall_changes=%0d want 6 0", beats.size(), stall_viol);
        end
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", i, beats[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp [6] = '{{1'b0, 32'h0000_0000}, {1'b0, 32'h0000_00AB}, {1'b1, 32'h0000_00AB},
                                 {1'b0, 32'h0001_0000}, {1'b0, 32'h0000_00CD}, {1'b1, 32'h0001_00CD}};
        do_reset();
        fork
            begin
                send_hdr(3'd0, 16'h0077);
                send_data(32'hFFFF_FFAB);
                send_hdr(3'd0, 16'h0000);
                send_data(32'h1234_56CD);
            end
            collect(6, 1'b0, 60);
        join
        checks++;
        if (beats.size() != 6) begin
            errors++;
            $display("FAIL b2b_beats: got %0d beats want 6", beats.size());
        end
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h want %h", i, beats[i], exp[i]);
            end
        end
        for (int i = 1; i < beat_cyc.size(); i++) begin
            checks++;
            if (beat_cyc[i] != beat_cyc[i-1] + 1) begin
                errors++;
                $display("FAIL b2b_gap%0d: beat at cycle %0d after %0d, want consecutive",
                         i, beat_cyc[i], beat_cyc[i-1]);
            end
        end
        checks++;
        if (seq !== 13'd2) begin
            errors++;
            $display("FAIL b2b_seq: got %0d want 2", seq);
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_hdr(3'd4, 16'd3);
        send_data(32'h0000_0001);
        send_data(32'h0000_0002);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0002) begin
            errors++;
            $display("FAIL abort_pre: v=%0b d=%h want 1 00000002", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_last, hdr_ready, data_ready, err, seq} !== 50'd0) begin
            errors++;
            $display("FAIL abort_outputs: v=%0b d=%h l=%0b hr=%0b dr=%0b e=%0b s=%0d, want all 0",
                     out_valid, out_data, out_last, hdr_ready, data_ready, err, seq);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        fork
            begin send_hdr(3'd1, 16'd0); send_data(32'hCAFE_F00D); end
            collect(3, 1'b0, 40);
        join
        checks++;
        if (beats.size() != 3) begin
            errors++;
            $display("FAIL abort_next_beats: got %0d want 3", beats.size());
        end
        else begin
            checks++;
            if (beats[0] !== {1'b0, 32'h2000_0000} || beats[2] !== {1'b1, 32'hEAFE_F00D}) begin
                errors++;
                $display("FAIL abort_next_frame: hdr=%h trl=%h want 0_20000000 1_eafef00d", beats[0], beats[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_int();
        test_string();
        test_empty_realv();
        test_reject();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
